// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM and hold/auto-repeat timing.
// Emits registered single-cycle press, release, long-press and repeat pulses plus a held level.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
  parameter int unsigned REPEAT_CYCLES     = 10_000_000,
  parameter bit          KEY_ACTIVE_LOW    = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_raw,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic key_held
);

  localparam int unsigned MaxDbLp   = (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ?
                                      DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;
  localparam int unsigned MaxCycles = (MaxDbLp > REPEAT_CYCLES) ? MaxDbLp : REPEAT_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] DbLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] LpLast  = CntW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CntW-1:0] RepLast = CntW'(REPEAT_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  // Raw level seen when the key is not pressed.
  localparam logic RelLevel = KEY_ACTIVE_LOW;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPressDb = 3'd1,
    StPressed = 3'd2,
    StHeld    = 3'd3,
    StRelDb   = 3'd4
  } state_e;

  logic            sync1;
  logic            sync2;
  logic            key_sync;
  state_e          state;
  logic [CntW-1:0] cnt;

  assign key_sync = KEY_ACTIVE_LOW ? ~sync2 : sync2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1         <= RelLevel;
      sync2         <= RelLevel;
      state         <= StIdle;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      key_held      <= 1'b0;
    end else begin
      sync1         <= key_raw;
      sync2         <= sync1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      cnt           <= cnt + CntOne;
      case (state)
        StIdle: begin
          cnt      <= '0;
          key_held <= 1'b0;
          if (key_sync) state <= StPressDb;
        end
        StPressDb: begin
          if (!key_sync) begin
            state <= StIdle;
            cnt   <= '0;
          end else if (cnt == DbLast) begin
            state       <= StPressed;
            cnt         <= '0;
            press_pulse <= 1'b1;
            key_held    <= 1'b1;
          end
        end
        StPressed: begin
          key_held <= 1'b1;
          if (!key_sync) begin
            state <= StRelDb;
            cnt   <= '0;
          end else if (cnt == LpLast) begin
            state        <= StHeld;
            cnt          <= '0;
            long_press   <= 1'b1;
            repeat_pulse <= 1'b1;
          end
        end
        StHeld: begin
          key_held <= 1'b1;
          if (!key_sync) begin
            state <= StRelDb;
            cnt   <= '0;
          end else if (cnt == RepLast) begin
            cnt          <= '0;
            repeat_pulse <= 1'b1;
          end
        end
        StRelDb: begin
          // A bounce back to pressed resumes holding without a second press event.
          if (key_sync) begin
            state <= StPressed;
            cnt   <= '0;
          end else if (cnt == DbLast) begin
            state         <= StIdle;
            cnt           <= '0;
            release_pulse <= 1'b1;
            key_held      <= 1'b0;
          end
        end
        default: begin
          state    <= StIdle;
          cnt      <= '0;
          key_held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: expected pulses are queued with their edge number
// when stimulus is driven and compared against the outputs sampled 1 time unit after each edge.
module tb_key_conditioner;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic key_raw = 1'b1;
  logic press_pulse;
  logic release_pulse;
  logic long_press;
  logic repeat_pulse;
  logic key_held;
  logic [3:0] act;

  int edge_n = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         edge_no;
    logic [3:0] mask;  // {press, release, long, repeat}
  } exp_t;

  exp_t sb[$];

  key_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(10),
    .REPEAT_CYCLES    (5),
    .KEY_ACTIVE_LOW   (1'b1)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .key_raw      (key_raw),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .key_held     (key_held)
  );

  assign act = {press_pulse, release_pulse, long_press, repeat_pulse};

  always #5 clock = ~clock;
  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic push(input int e, input logic [3:0] m);
    exp_t x;
    x.edge_no = e;
    x.mask    = m;
    sb.push_back(x);
  endtask

  // Advance one edge and collect the pulses expected in the cycle that follows it.
  task automatic tick(output logic [3:0] exp);
    exp_t x;
    @(posedge clock);
    #1;
    exp = '0;
    while (sb.size() > 0 && sb[0].edge_no <= edge_n) begin
      x = sb.pop_front();
      exp |= x.mask;
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({act, key_held} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async got %b expected 00000", {act, key_held});
    end
    for (int i = 0; i < 6; i++) begin
      key_raw = i[0];
      @(posedge clock);
      #1;
      checks++;
      if ({act, key_held} !== 5'b0) begin
        errors++;
        $display("FAIL reset_hold edge %0d got %b expected 00000", edge_n, {act, key_held});
      end
    end
    key_raw = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL reset_idle edge %0d pulses got %b expected %b", edge_n, act, exp);
      end
      checks++;
      if (key_held !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_held edge %0d got %b expected 0", edge_n, key_held);
      end
    end
  endtask

  task automatic test_clean_press;
    logic [3:0] exp;
    int p;
    p = edge_n + 7;
    key_raw = 1'b0;
    push(p, 4'b1000);
    for (int i = 0; i < 12; i++) begin
      tick(exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL clean_press edge %0d pulses got %b expected %b", edge_n, act, exp);
      end
      checks++;
      if (key_held !== 1'(edge_n >= p)) begin
        errors++;
        $display("FAIL clean_press_held edge %0d got %b expected %b", edge_n, key_held,
                 1'(edge_n >= p));
      end
    end
  endtask

  task automatic test_release;
    logic [3:0] exp;
    int r;
    r = edge_n + 7;
    key_raw = 1'b1;
    push(r, 4'b0100);
    for (int i = 0; i < 10; i++) begin
      tick(exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL release edge %0d pulses got %b expected %b", edge_n, act, exp);
      end
      checks++;
      if (key_held !== 1'(edge_n < r)) begin
        errors++;
        $display("FAIL release_held edge %0d got %b expected %b", edge_n, key_held,
                 1'(edge_n < r));
      end
    end
  endtask

  task automatic test_bounce;
    logic [3:0] exp;
    for (int c = 0; c < 33; c++) begin
      key_raw = !(c < 25 && (c % 5) < 3);
      tick(exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL bounce edge %0d pulses got %b expected %b", edge_n, act, exp);
      end
      checks++;
      if (key_held !== 1'b0) begin
        errors++;
        $display("FAIL bounce_held edge %0d got %b expected 0", edge_n, key_held);
      end
    end
  endtask

  task automatic test_long_press;
    logic [3:0] exp;
    int p;
    p = edge_n + 7;
    key_raw = 1'b0;
    push(p, 4'b1000);
    push(p + 10, 4'b0011);
    for (int k = 15; k <= 40; k += 5) push(p + k, 4'b0001);
    for (int i = 0; i < 48; i++) begin
      tick(exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL long_press edge %0d pulses got %b expected %b", edge_n, act, exp);
      end
      checks++;
      if (key_held !== 1'(edge_n >= p)) begin
        errors++;
        $display("FAIL long_press_held edge %0d got %b expected %b", edge_n, key_held,
                 1'(edge_n >= p));
      end
    end
  endtask

  task automatic test_release_bounce;
    logic [3:0] exp;
    int p;
    int r;
    p = edge_n + 7;
    key_raw = 1'b0;
    push(p, 4'b1000);
    for (int i = 0; i < 25; i++) begin
      if (i == 9) begin
        r = edge_n;
        key_raw = 1'b1;
      end
      if (i == 11) begin
        key_raw = 1'b0;
        push(r + 15, 4'b0011);  // re-entry to PRESSED at r+5, long press 10 edges later
      end
      tick(exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL release_bounce edge %0d pulses got %b expected %b", edge_n, act, exp);
      end
      checks++;
      if (key_held !== 1'(edge_n >= p)) begin
        errors++;
        $display("FAIL release_bounce_held edge %0d got %b expected %b", edge_n, key_held,
                 1'(edge_n >= p));
      end
    end
  endtask

  task automatic test_reset_mid_hold;
    logic [3:0] exp;
    int f;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({act, key_held} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_hold_async got %b expected 00000", {act, key_held});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if ({act, key_held} !== 5'b0) begin
        errors++;
        $display("FAIL reset_mid_hold edge %0d got %b expected 00000", edge_n, {act, key_held});
      end
    end
    reset_n = 1'b1;
    f = edge_n + 7;
    push(f, 4'b1000);
    for (int i = 0; i < 10; i++) begin
      tick(exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL reset_repress edge %0d pulses got %b expected %b", edge_n, act, exp);
      end
      checks++;
      if (key_held !== 1'(edge_n >= f)) begin
        errors++;
        $display("FAIL reset_repress_held edge %0d got %b expected %b", edge_n, key_held,
                 1'(edge_n >= f));
      end
    end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_release;
    test_bounce;
    test_long_press;
    test_release;
    test_release_bounce;
    test_reset_mid_hold;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending %0d expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions one raw push-button into clean, single-cycle event pulses for the alarm-clock controllers.
- press_pulse drives the mode state machine's switch_signal input, one pulse per physical press.
- long_press and repeat_pulse let the time/alarm setting logic auto-increment while a key is held.
- One instance per key; all outputs registered.

Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive stable cycles required to accept a press or release (20 ms at 50 MHz); must be >= 2.
- LONG_PRESS_CYCLES, default 50_000_000: cycles in PRESSED before HELD is entered; must be >= 2.
- REPEAT_CYCLES, default 10_000_000: period of repeat_pulse in HELD; must be >= 2.
- KEY_ACTIVE_LOW, default 1: 1 = key_raw reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- key_raw  in  1  asynchronous raw button level.
- press_pulse  out  1  one-cycle pulse on an accepted press (to switch_signal).
- release_pulse  out  1  one-cycle pulse on an accepted release.
- long_press  out  1  one-cycle pulse on entry to HELD.
- repeat_pulse  out  1  one-cycle auto-repeat pulse while HELD.
- key_held  out  1  level; 1 in PRESSED, HELD, RELEASE_DEBOUNCE.

Behaviour:
- Reset (async assert): all outputs 0, state IDLE, counter 0, both synchronizer flops at the "released" level.
  - A key held through reset release is debounced and then produces press_pulse.
- Synchronizer: 2 flops, then polarity-normalised key_sync (1 = pressed).
- Edge numbering: edge 1 is the first edge sampling the new raw level; key_sync shows it after edge 2; the FSM acts on it at edge 3.
- Counter: single, width $clog2(max of the three parameters)+1, saturating never needed. Cleared on every state change.
- IDLE:
  - key_sync=1 -> PRESS_DEBOUNCE, cnt=0.
- PRESS_DEBOUNCE:
  - key_sync=0 -> IDLE; no output.
  - key_sync=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, press_pulse=1 for that one cycle.
  - Otherwise cnt++.
  - Press latency: press_pulse high in the cycle after edge DEBOUNCE_CYCLES+3.
- PRESSED:
  - key_sync=0 -> RELEASE_DEBOUNCE.
  - cnt==LONG_PRESS_CYCLES-1 -> HELD; long_press=1 and repeat_pulse=1 in the same cycle.
  - Otherwise cnt++.
- HELD:
  - key_sync=0 -> RELEASE_DEBOUNCE.
  - cnt==REPEAT_CYCLES-1 -> repeat_pulse=1, cnt=0.
  - Otherwise cnt++.
- RELEASE_DEBOUNCE:
  - key_sync=1 -> PRESSED with cnt=0; no new press_pulse; hold timing restarts.
  - key_sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse=1.
  - Otherwise cnt++.
  - Release latency: DEBOUNCE_CYCLES+3 edges.
- Pulse rules: every pulse output is exactly one cycle wide; press_pulse and release_pulse are never high together.
- Illegal or unreachable state encoding -> IDLE on the next edge, outputs 0.
- Reset mid-operation: immediate return to reset values; no pulse is emitted on reset release.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, REPEAT_CYCLES=5, KEY_ACTIVE_LOW=1.
- Reset: reset_n=0 with key_raw toggling -> all outputs 0. Release reset with key_raw=1 for 20 cycles -> no pulses.
- Clean press: key_raw=0 from edge 1, held 12 cycles -> press_pulse high only in the cycle after edge 7; key_held rises in the same cycle; no long_press.
- Bounce reject:
  - key_raw=0 for 3 edges, then 1 -> no press_pulse, key_held stays 0.
  - Repeat the glitch 5 times with 2-cycle gaps -> still no output.
- Long press: hold 40 cycles after the press_pulse edge P -> long_press and repeat_pulse at P+10; repeat_pulse again at P+15, P+20, P+25, P+30, P+35, P+40; exactly one press_pulse.
- Release and release bounce:
  - Release at edge R -> release_pulse after edge R+7; key_held falls in that same cycle.
  - Separately, release for 2 cycles then re-press -> no release_pulse, no second press_pulse, key_held stays 1; long_press 10 edges after re-entry to PRESSED.
- Reset mid-hold: assert reset_n=0 in HELD -> outputs 0 immediately. Release reset with the key still pressed -> press_pulse DEBOUNCE_CYCLES+3 edges after the first edge following reset release.
